// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and fetch-state encoding shared across the CPU
package cpu_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;
    localparam logic [3:0] AM_IMM  = 4'd8;

    localparam int OPC_LSB = 28;
    localparam int MM_LSB  = 24;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DRAIN} fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: sequential PC increment and the PC value to load in IDLE (branch target or hold)
module pc_next_calc #(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ir_pc,
    input  logic [OFF_W-1:0]  off,
    input  logic              pc_sel,
    input  logic              br_sel,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] pc_br
);

    logic [OFF_W-1:0] rel;

    // OFF_W >= ADDR_W, so a modular add at OFF_W bits equals the sign-extended add truncated
    assign rel    = OFF_W'(ir_pc) + off;
    assign pc_inc = pc + ADDR_W'(1);
    assign pc_br  = !pc_sel ? pc : br_sel ? off[ADDR_W-1:0] : rel[ADDR_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR holder running the request/valid handshake to instruction memory
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              OFF_W     = 16
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              PC_RST,
    input  logic              PC_WRITE,
    input  logic              PC_SEL,
    input  logic              BR_SEL,
    output logic              IM_REQ,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic [31:0]       IM_RDATA,
    input  logic              IM_VALID,
    output logic [31:0]       INSTR,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              FETCH_BUSY
);

    fetch_state_e      state;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc, ir_pc, pc_inc, pc_br;
    logic              pw_q, pend, pw_edge, mem_out, go;

    assign pw_edge    = PC_WRITE & ~pw_q;
    // a read is still in flight and will not complete this cycle
    assign mem_out    = (state == F_WAIT || state == F_DRAIN) && !IM_VALID;
    assign go         = pend | pw_edge;
    assign INSTR      = ir;
    assign OPCODE     = ir[OPC_LSB +: 4];
    assign MM         = ir[MM_LSB +: 4];
    assign PC         = pc;
    assign IR_PC      = ir_pc;
    assign FETCH_BUSY = state != F_IDLE;

    pc_next_calc #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_pc_next (
        .pc     (pc),
        .ir_pc  (ir_pc),
        .off    (ir[OFF_W-1:0]),
        .pc_sel (PC_SEL),
        .br_sel (BR_SEL),
        .pc_inc (pc_inc),
        .pc_br  (pc_br)
    );

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state   <= F_IDLE;
            pc      <= RESET_VEC;
            ir      <= '0;
            ir_pc   <= RESET_VEC;
            IM_REQ  <= 1'b0;
            IM_ADDR <= RESET_VEC;
            pw_q    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            pw_q   <= PC_WRITE;
            IM_REQ <= 1'b0;
            if (PC_RST) begin
                pc    <= RESET_VEC;
                ir    <= '0;
                pend  <= 1'b0;
                state <= mem_out ? F_DRAIN : F_IDLE;
            end else begin
                case (state)
                    F_IDLE: begin
                        pc <= pc_br;
                        if (pw_edge) begin
                            state   <= F_REQ;
                            IM_REQ  <= 1'b1;
                            IM_ADDR <= pc_br;
                        end
                    end
                    F_REQ: state <= F_WAIT;
                    F_WAIT: if (IM_VALID) begin
                        ir    <= IM_RDATA;
                        ir_pc <= pc;
                        pc    <= pc_inc;
                        state <= F_IDLE;
                    end
                    F_DRAIN: begin
                        pend <= go;
                        if (IM_VALID) begin
                            pend    <= 1'b0;
                            state   <= go ? F_REQ : F_IDLE;
                            IM_REQ  <= go;
                            IM_ADDR <= pc;
                        end
                    end
                    default: state <= F_IDLE;
                endcase
            end
        end
    end

    a_no_sel_busy: assert property (@(posedge CLK) disable iff (!RST_F) FETCH_BUSY |-> !PC_SEL);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the multicycle CPU, directly upstream of the control FSM. Holds the program counter (PC) and instruction register (IR), and runs a request/valid handshake to instruction memory. Presents OPCODE/MM to the control FSM and applies its PC_RST, PC_WRITE, PC_SEL and BR_SEL commands, including relative and absolute branch target formation.

Parameters:
ADDR_W, 16, PC/instruction-memory word-address width
RESET_VEC, 0, PC value after reset or PC_RST
OFF_W, 16, width of the branch offset/address field Instr[OFF_W-1:0]; must be >= ADDR_W

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  reset, asynchronous, active-low
PC_RST  in  1  synchronous PC clear from ctrl
PC_WRITE  in  1  fetch command from ctrl; level, edge-detected internally
PC_SEL  in  1  1 = load branch target into PC
BR_SEL  in  1  1 = absolute target, 0 = relative target
IM_REQ  out  1  memory read request, one-cycle pulse
IM_ADDR  out  ADDR_W  memory read address
IM_RDATA  in  32  memory read data
IM_VALID  in  1  IM_RDATA valid, one cycle, latency >= 1 cycle after IM_REQ
INSTR  out  32  current IR
OPCODE  out  4  IR[31:28]
MM  out  4  IR[27:24]
PC  out  ADDR_W  current PC
IR_PC  out  ADDR_W  address the IR was fetched from
FETCH_BUSY  out  1  high in REQ, WAIT, DRAIN

Behaviour:
- Reset (RST_F low, async): PC=RESET_VEC, IR=0 (OPCODE=noop), IR_PC=RESET_VEC, IM_REQ=0, IM_ADDR=RESET_VEC, state IDLE, FETCH_BUSY=0, PC_WRITE edge register cleared.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: a rising edge of PC_WRITE (PC_WRITE=1 and previous-cycle PC_WRITE=0) -> REQ. PC_WRITE held high starts exactly one fetch.
- REQ (1 cycle): IM_REQ=1, IM_ADDR=PC -> WAIT.
- WAIT: on IM_VALID: IR<=IM_RDATA, IR_PC<=PC, PC<=PC+1 (mod 2^ADDR_W) -> IDLE. Minimum fetch latency, PC_WRITE edge to new OPCODE visible: 3 cycles with 1-cycle memory.
- Branch: PC_SEL=1 sampled in IDLE loads PC in that cycle. BR_SEL=1: PC<=IR[ADDR_W-1:0]. BR_SEL=0: PC<=IR_PC + sign-extended IR[OFF_W-1:0], truncated to ADDR_W (wraps). IR is unchanged.
- PC_SEL while FETCH_BUSY: ignored (ctrl contract violation). Assertion flags it.
- Simultaneous PC_SEL and PC_WRITE edge in IDLE: PC loads the target, and the fetch starts the next cycle at the new PC.
- PC_RST=1 (sync, highest priority): PC<=RESET_VEC, IR<=0. From IDLE/REQ -> IDLE. From WAIT -> DRAIN. A pending PC_WRITE edge is discarded.
- DRAIN: waits for the outstanding IM_VALID, discards the data (IR/PC untouched) -> IDLE. A PC_WRITE edge seen in DRAIN is remembered and enters REQ after the drain.
- IM_VALID in IDLE/REQ: ignored.
- OPCODE/MM are purely combinational from IR. There is no other logic between IR and the outputs.

Decomposition:
- cpu_pkg: opcode constants (noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu=8, hlt=15), addressing mode am_imm=8, instruction field positions, fetch state encoding.
- Sub-module pc_next_calc (combinational): inputs PC, IR_PC, IR, PC_SEL, BR_SEL. Outputs the incremented PC and the branch target.

Test Plan:
- Reset, then a PC_WRITE pulse with 1-cycle memory returning 32'h8100_0005 -> IM_ADDR=0, OPCODE=8, MM=1, IR_PC=0, PC=1; FETCH_BUSY high 2 cycles.
- PC_WRITE held high 5 cycles -> exactly one IM_REQ.
- IR fetched at 0x0010 with Instr[15:0]=16'hFFFC, PC_SEL=1, BR_SEL=0 -> PC=0x000C. Same IR with BR_SEL=1 -> PC=0xFFFC.
- PC=0xFFFF fetch -> PC wraps to 0x0000. Relative offset +2 from IR_PC=0xFFFF -> PC=0x0001.
- PC_RST during WAIT with 4-cycle memory latency -> PC=RESET_VEC, OPCODE=0, late IM_VALID data discarded, state returns to IDLE.
- PC_SEL and PC_WRITE edge in the same IDLE cycle (absolute target 0x0040) -> next IM_ADDR=0x0040.
